hw_stack: RTL and testbench
===========================

Name: hw_stack

Overview:
- Hardware LIFO directly downstream of the instruction decoder; consumes its stack_en, stack_rw and stack_rst strobes.
- PSH stores the register value selected by s1 (Rs1) onto the stack.
- POP returns the top entry on data_out. The register file latches it via s3/Rd during EXEC2.
- Tracks occupancy and reports overflow/underflow as sticky error flags for the STP/halt logic and for debug.

Parameters:
- WIDTH, 16, data word width (matches the register file and bus width).
- DEPTH, 16, number of entries; power of two, minimum 2.
- PW, 4, pointer width = log2(DEPTH).

Ports:
- CLK  in  1  system clock, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- stack_en  in  1  stack operation enable from the decoder.
- stack_rw  in  1  1 = push, 0 = pop; only meaningful when stack_en = 1.
- stack_rst  in  1  synchronous clear from the decoder (asserted for STP).
- data_in  in  WIDTH  push data (bus driven from the s1-selected register).
- data_out  out  WIDTH  registered popped value; held until the next pop or clear.
- sp  out  PW+1  current occupancy, 0..DEPTH.
- empty  out  1  sp == 0 (combinational from sp).
- full  out  1  sp == DEPTH (combinational from sp).
- ovf  out  1  sticky: a push was attempted while full.
- unf  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (RSTn = 0, asynchronous):
  - sp = 0, data_out = 0, ovf = 0, unf = 0, pop_phase = 0.
  - Memory contents are not reset.
- Priority, evaluated per rising edge: stack_rst > push > pop.
- stack_rst = 1 (synchronous): same clear as reset, regardless of stack_en.
- Push: stack_en = 1 and stack_rw = 1.
  - Not full: mem[sp] <= data_in, sp <= sp + 1.
  - Full: no write, sp unchanged, ovf <= 1.
  - pop_phase <= 0 in both cases.
  - data_out is unchanged.
- Pop: the decoder holds stack_en = 1, stack_rw = 0 for two consecutive cycles (EXEC1 then EXEC2). An internal 1-bit pop_phase state machine distinguishes the two cycles:
  - IDLE (pop_phase = 0), pop request, not empty: data_out <= mem[sp - 1], sp <= sp - 1, go to HOLD.
  - IDLE, pop request, empty: data_out <= 0, sp unchanged, unf <= 1, go to HOLD.
  - HOLD (pop_phase = 1), pop request: no pointer or data change, go to IDLE. This is the EXEC2 writeback cycle; data_out is stable throughout it.
  - HOLD, no pop request: go to IDLE, with no other effect. This tolerates single-cycle strobes.
  - Any cycle with stack_en = 0: pop_phase <= 0.
- Latency:
  - Popped value is visible on data_out one cycle after the first pop-enable edge, i.e. throughout EXEC2.
  - A push is visible to a pop issued in the immediately following cycle (no hazard).
- Pointer arithmetic:
  - sp is PW+1 bits; it never wraps and saturates at 0 and DEPTH via the full/empty guards.
  - Memory is indexed by the low PW bits of sp (push) or of sp - 1 (pop).
- Sticky flags clear only on RSTn or stack_rst.
- Reset mid-pop (RSTn or stack_rst during HOLD): pop_phase returns to 0. data_out is cleared and the in-flight value is lost, which is acceptable since STP halts the CPU.
- stack_rw = 1 with stack_en = 0: no effect.

Test Plan:
- Reset, then push 0x1234, 0xBEEF -> sp = 2. Pop (two-cycle en) -> data_out = 0xBEEF during the 2nd cycle, sp = 1. Pop -> data_out = 0x1234, sp = 0, empty = 1, unf = 0.
- Push DEPTH values 0x0000..0x000F -> full = 1, sp = 16. Push 0xFFFF -> ovf = 1, sp = 16. Pop sequence then returns 0x000F down to 0x0000 (0xFFFF never stored).
- Pop on an empty stack -> data_out = 0, unf = 1, sp = 0. A subsequent push 0x00AA then pop -> data_out = 0x00AA, unf remains 1.
- Single-cycle pop strobe followed immediately by a second two-cycle pop with 3 entries -> exactly two entries consumed, sp = 1, data_out = 2nd-from-top value.
- stack_rst asserted together with push, with sp = 5 and ovf = 1 -> next cycle sp = 0, ovf = 0, data_out = 0, no write.
- RSTn pulsed low between clock edges during the HOLD cycle of a pop -> outputs clear immediately without waiting for CLK. After release a push 0x5555 then pop returns 0x5555 with sp = 0.

Source files
------------

// File: rtl/hw_stack_if.sv
// Decoder-to-stack bus for hw_stack: operation strobes and push data in,
// popped data, occupancy and sticky error flags out.
interface hw_stack_if #(
    parameter int WIDTH = 16,
    parameter int PW    = 4
);
    logic             stack_en;
    logic             stack_rw;
    logic             stack_rst;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [PW:0]      sp;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             unf;

    modport master (
        output stack_en, stack_rw, stack_rst, data_in,
        input  data_out, sp, empty, full, ovf, unf
    );

    modport slave (
        input  stack_en, stack_rw, stack_rst, data_in,
        output data_out, sp, empty, full, ovf, unf
    );
endinterface

// File: rtl/hw_stack.sv
// Hardware LIFO fed by the instruction decoder: single-cycle push, two-cycle
// pop (EXEC1 loads data_out, EXEC2 holds it), sticky overflow/underflow flags.
module hw_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int PW    = 4
) (
    input  logic       CLK,
    input  logic       RSTn,
    hw_stack_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } pop_phase_t;

    localparam logic [PW:0]   SP_MAX = DEPTH[PW:0];
    localparam logic [PW:0]   SP_ONE = {{PW{1'b0}}, 1'b1};
    localparam logic [PW-1:0] IX_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];

    pop_phase_t       state_q, state_d;
    logic [PW:0]      sp_q, sp_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             push_req;
    logic             pop_req;
    logic             is_full;
    logic             is_empty;
    logic             wr_en;
    logic [PW-1:0]    wr_idx;
    logic [PW-1:0]    rd_idx;

    assign push_req = bus.stack_en &  bus.stack_rw;
    assign pop_req  = bus.stack_en & ~bus.stack_rw;
    assign is_full  = (sp_q == SP_MAX);
    assign is_empty = (sp_q == '0);
    assign wr_idx   = sp_q[PW-1:0];
    assign rd_idx   = sp_q[PW-1:0] - IX_ONE;

    // Priority: synchronous clear, then push, then pop.
    always_comb begin
        state_d = IDLE;
        sp_d    = sp_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        wr_en   = 1'b0;

        if (bus.stack_rst) begin
            sp_d   = '0;
            data_d = '0;
            ovf_d  = 1'b0;
            unf_d  = 1'b0;
        end else if (push_req) begin
            if (!is_full) begin
                wr_en = 1'b1;
                sp_d  = sp_q + SP_ONE;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (pop_req) begin
            unique case (state_q)
                IDLE: begin
                    state_d = HOLD;
                    if (!is_empty) begin
                        data_d = mem[rd_idx];
                        sp_d   = sp_q - SP_ONE;
                    end else begin
                        data_d = '0;
                        unf_d  = 1'b1;
                    end
                end
                HOLD: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            sp_q    <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem[wr_idx] <= bus.data_in;
        end
    end

    assign bus.data_out = data_q;
    assign bus.sp       = sp_q;
    assign bus.empty    = is_empty;
    assign bus.full     = is_full;
    assign bus.ovf      = ovf_q;
    assign bus.unf      = unf_q;

endmodule

// File: tb/tb_hw_stack.sv
// Scoreboard bench for hw_stack: directed scenarios plus random traffic,
// checked every cycle against a queue-based LIFO model.
module tb_hw_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;
    localparam int PW    = 4;

    typedef struct packed {
        logic [WIDTH-1:0] dout;
        logic [PW:0]      sp;
        logic             empty;
        logic             full;
        logic             ovf;
        logic             unf;
    } obs_t;

    logic clk = 1'b0;
    logic rstn;

    hw_stack_if #(.WIDTH(WIDTH), .PW(PW)) bus ();

    hw_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) dut (
        .CLK (clk),
        .RSTn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue used as a stack.
    logic [WIDTH-1:0] m_stk [$];
    logic [WIDTH-1:0] m_dout;
    logic             m_ovf;
    logic             m_unf;
    bit               m_second;

    obs_t exp_q [$];
    int   n_cmp = 0;
    int   n_err = 0;
    event async_ev;

    function automatic void model_clear();
        m_stk.delete();
        m_dout   = '0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
        m_second = 1'b0;
    endfunction

    function automatic void model_step(input logic en, input logic rw,
                                       input logic rst, input logic [WIDTH-1:0] din);
        if (rst) begin
            model_clear();
        end else if (en && rw) begin
            if (m_stk.size() < DEPTH) m_stk.push_back(din);
            else m_ovf = 1'b1;
            m_second = 1'b0;
        end else if (en && !rw) begin
            if (!m_second) begin
                if (m_stk.size() > 0) m_dout = m_stk.pop_back();
                else begin
                    m_dout = '0;
                    m_unf  = 1'b1;
                end
                m_second = 1'b1;
            end else begin
                m_second = 1'b0;
            end
        end else begin
            m_second = 1'b0;
        end
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.dout  = m_dout;
        o.sp    = (PW+1)'(m_stk.size());
        o.empty = (m_stk.size() == 0);
        o.full  = (m_stk.size() == DEPTH);
        o.ovf   = m_ovf;
        o.unf   = m_unf;
        return o;
    endfunction

    // Monitor: compares every pending expectation on the falling edge or on demand.
    initial begin
        forever begin
            @(negedge clk or async_ev);
            while (exp_q.size() > 0) begin
                obs_t e, a;
                e = exp_q.pop_front();
                a.dout  = bus.data_out;
                a.sp    = bus.sp;
                a.empty = bus.empty;
                a.full  = bus.full;
                a.ovf   = bus.ovf;
                a.unf   = bus.unf;
                n_cmp++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL obs @%0t: got dout=%h sp=%0d e=%b f=%b ovf=%b unf=%b, want dout=%h sp=%0d e=%b f=%b ovf=%b unf=%b",
                             $time, a.dout, a.sp, a.empty, a.full, a.ovf, a.unf,
                             e.dout, e.sp, e.empty, e.full, e.ovf, e.unf);
                end
            end
        end
    end

    task automatic cycle(input logic en, input logic rw, input logic rst,
                         input logic [WIDTH-1:0] din);
        bus.stack_en  = en;
        bus.stack_rw  = rw;
        bus.stack_rst = rst;
        bus.data_in   = din;
        @(posedge clk);
        model_step(en, rw, rst, din);
        exp_q.push_back(model_obs());
        @(negedge clk);
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        cycle(1'b1, 1'b1, 1'b0, v);
    endtask

    task automatic pop2();
        cycle(1'b1, 1'b0, 1'b0, WIDTH'($urandom));
        cycle(1'b1, 1'b0, 1'b0, WIDTH'($urandom));
    endtask

    task automatic idle();
        cycle(1'b0, 1'($urandom), 1'b0, WIDTH'($urandom));
    endtask

    // Called on a falling edge; pulses RSTn low between clock edges.
    task automatic async_pulse();
        #2 rstn = 1'b0;
        #1 model_clear();
        exp_q.push_back(model_obs());
        -> async_ev;
        #1 bus.stack_en = 1'b0;
        rstn = 1'b1;
        @(posedge clk);
        model_step(1'b0, bus.stack_rw, 1'b0, bus.data_in);
        exp_q.push_back(model_obs());
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn          = 1'b0;
        bus.stack_en  = 1'b0;
        bus.stack_rw  = 1'b0;
        bus.stack_rst = 1'b0;
        bus.data_in   = '0;
        model_clear();
        #3;
        exp_q.push_back(model_obs());
        -> async_ev;
        @(negedge clk);
        rstn = 1'b1;

        push(16'h1234);
        push(16'hBEEF);
        pop2();
        pop2();

        for (int unsigned i = 0; i < DEPTH; i++) push(WIDTH'(i));
        push(16'hFFFF);
        for (int unsigned i = 0; i < DEPTH; i++) pop2();

        pop2();
        push(16'h00AA);
        pop2();

        cycle(1'b0, 1'b0, 1'b1, '0);
        push(16'h0011);
        push(16'h0022);
        push(16'h0033);
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, 1'b0, '0);
        pop2();

        for (int unsigned i = 0; i < DEPTH + 1; i++) push(WIDTH'(16'h0100 + i));
        for (int unsigned i = 0; i < DEPTH - 5; i++) pop2();
        cycle(1'b1, 1'b1, 1'b1, 16'h7777);
        idle();

        push(16'h0A0A);
        push(16'h0B0B);
        cycle(1'b1, 1'b0, 1'b0, '0);
        async_pulse();
        push(16'h5555);
        pop2();

        for (int unsigned n = 0; n < 1500; n++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 38) push(WIDTH'($urandom));
            else if (r < 70) pop2();
            else if (r < 78) begin
                cycle(1'b1, 1'b0, 1'b0, '0);
                idle();
            end else if (r < 86) idle();
            else if (r < 92) begin
                push(WIDTH'($urandom));
                pop2();
            end else if (r < 95) begin
                for (int unsigned k = 0; k < 20; k++) push(WIDTH'($urandom));
            end else if (r < 97) begin
                for (int unsigned k = 0; k < 20; k++) pop2();
            end else cycle(1'($urandom), 1'($urandom), 1'b1, WIDTH'($urandom));
        end

        idle();
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
